// File: rtl/valid_pipe_pkg.sv
// rtl/valid_pipe_pkg.sv - shared sizing helpers for valid_pipe (optional skid: VALID_PIPE_SKID_EN)
package valid_pipe_pkg;

`ifdef VALID_PIPE_SKID_EN
  localparam int SKID_ENTRIES = 1;
`else
  localparam int SKID_ENTRIES = 0;
`endif

  // Occupancy counter is sized for stages plus one skid entry in every build
  function automatic int count_width(input int stages);
    return $clog2(stages + 2);
  endfunction

  // Beats the block can hold at once
  function automatic int capacity(input int stages);
    return stages + SKID_ENTRIES;
  endfunction

endpackage

// File: rtl/valid_pipe_stage.sv
// rtl/valid_pipe_stage.sv - one bubble-collapsing valid/data register pair
module valid_pipe_stage #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_rdy_next,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_rdy
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // An empty stage can always take a beat, so bubbles collapse forward
  assign o_rdy   = i_rdy_next | ~r_valid;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // Valid follows the upstream valid when ready; data only moves with a real beat
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (i_flush) begin
        r_valid <= 1'b0;
      end else if (o_rdy) begin
        r_valid <= i_valid;
      end
      if (!i_flush && o_rdy && i_valid) begin
        r_data <= i_data;
      end
    end
  end

endmodule

// File: rtl/valid_pipe.sv
// rtl/valid_pipe.sv - bubble-collapsing valid/ready pipeline, optional skid via VALID_PIPE_SKID_EN
module valid_pipe
  import valid_pipe_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             valid_up,
  input  logic [WIDTH-1:0]                 data_up,
  output logic                             ready_up,
  output logic                             valid_down,
  output logic [WIDTH-1:0]                 data_down,
  input  logic                             ready_down,
  output logic [count_width(STAGES)-1:0]   count
);

  localparam int CW       = count_width(STAGES);
  localparam int CAPACITY = capacity(STAGES);

  logic             w_v    [0:STAGES-1];
  logic [WIDTH-1:0] w_data [0:STAGES-1];
  logic             w_rdy  [0:STAGES];
  logic             w_in_valid;
  logic [WIDTH-1:0] w_in_data;
  logic             w_accept;
  logic             w_pop;

  assign w_rdy[STAGES] = ready_down;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic             w_src_valid;
      logic [WIDTH-1:0] w_src_data;
      if (gi == 0) begin : g_first
        assign w_src_valid = w_in_valid;
        assign w_src_data  = w_in_data;
      end else begin : g_rest
        assign w_src_valid = w_v[gi-1];
        assign w_src_data  = w_data[gi-1];
      end
      valid_pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_flush    (flush),
        .i_valid    (w_src_valid),
        .i_data     (w_src_data),
        .i_rdy_next (w_rdy[gi+1]),
        .o_valid    (w_v[gi]),
        .o_data     (w_data[gi]),
        .o_rdy      (w_rdy[gi])
      );
    end
  endgenerate

  assign valid_down = w_v[STAGES-1];
  assign data_down  = w_data[STAGES-1];
  assign w_pop      = valid_down & ready_down;

`ifdef VALID_PIPE_SKID_EN
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_ready_up;

  // A held skid beat always goes to stage 0 ahead of new input
  assign w_in_valid = r_skid_valid | valid_up;
  assign w_in_data  = r_skid_valid ? r_skid_data : data_up;
  assign w_accept   = valid_up & r_ready_up;
  assign ready_up   = r_ready_up;

  // Skid catches a beat stage 0 cannot take; ready_up is kept as a flop mirroring ~skid_valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_ready_up   <= 1'b1;
    end else if (flush) begin
      r_skid_valid <= 1'b0;
      r_ready_up   <= 1'b1;
    end else if (r_skid_valid) begin
      if (w_rdy[0]) begin
        r_skid_valid <= 1'b0;
        r_ready_up   <= 1'b1;
      end
    end else if (w_accept && !w_rdy[0]) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= data_up;
      r_ready_up   <= 1'b0;
    end
  end
`else
  assign w_in_valid = valid_up;
  assign w_in_data  = data_up;
  assign ready_up   = w_rdy[0];
  assign w_accept   = valid_up & w_rdy[0];
`endif

  // Occupancy: +1 per accept, -1 per pop, cleared by flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (w_accept && !w_pop && count != CAPACITY[CW-1:0]) begin
      count <= count + 1'b1;
    end else if (w_pop && !w_accept && count != '0) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: doc/valid_pipe.md
VALID_PIPE -- requirements
Module: valid_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 4: data bits per beat (>=1).
REQ-002 SHALL have parameter STAGES, default 2: number of bubble-collapsing register stages (>=1).
REQ-003 SHALL have port clk  input  1  rising-edge clock; the block uses one clock only.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port flush  input  1  synchronous discard of all held beats.
REQ-006 SHALL have port valid_up  input  1  upstream beat present.
REQ-007 SHALL have port data_up  input  WIDTH  upstream payload.
REQ-008 SHALL have port ready_up  output  1  block accepts the beat this cycle.
REQ-009 SHALL have port valid_down  output  1  downstream beat present (last stage valid).
REQ-010 SHALL have port data_down  output  WIDTH  downstream payload (last stage data).
REQ-011 SHALL have port ready_down  input  1  downstream accepts.
REQ-012 SHALL have port count  output  $clog2(STAGES+2)  number of beats held (stages plus skid entry).

Function
REQ-013 SHALL transfer upstream on valid_up && ready_up at a rising edge, and downstream on valid_down && ready_down at a rising edge.
REQ-014 SHALL give each stage i a ready term: rdy[i] = rdy[i+1] || ~v[i], with rdy[STAGES] = ready_down (bubble collapsing).
REQ-015 SHALL load stage i from stage i-1 (stage 0 from the input) when rdy[i] is 1; v[i] takes the upstream valid.
REQ-016 SHALL load data[i] only when rdy[i] && upstream valid; otherwise data[i] holds.
REQ-017 SHALL give a minimum latency of STAGES edges from acceptance to valid_down with ready_down held at 1, and sustain 1 beat/cycle.
REQ-018 SHALL never drop, duplicate or reorder a beat; data_down SHALL be stable while valid_down && ~ready_down.
REQ-019 SHALL, with all stages full and ready_down=0, hold ready_up=0; one downstream pop with ready_down=1 SHALL allow acceptance in the same cycle (no-skid build).
REQ-020 SHALL update count every edge: +1 on accept, -1 on pop, unchanged on both or neither; count never exceeds capacity.
REQ-021 SHALL, on flush=1 at an edge, clear all valid bits and count to 0; flush has priority, and a beat offered in that cycle is discarded; data registers hold.
REQ-022 SHALL NOT let valid_down depend combinationally on valid_up.

Reset
REQ-023 SHALL, while rst=0, force all valid bits, the skid valid and count to 0, and all data registers to 0, asynchronously.
REQ-024 SHALL drive ready_up=1 during reset and on the first edge after release; the first beat is accepted then.
REQ-025 SHALL discard in-flight beats when reset asserts mid-operation; no beat emerges after release without new input.

Configuration
REQ-026 SHALL support macro VALID_PIPE_SKID_EN; when defined, a 1-entry skid register sits ahead of stage 0, and ready_up is a flop output equal to ~skid_valid.
REQ-027 SHALL, with VALID_PIPE_SKID_EN, bypass the skid when it is empty and rdy[0]=1 (no extra latency), and capture the beat into the skid when rdy[0]=0; skid drains to stage 0 before new input; capacity = STAGES+1.
REQ-028 SHALL, without VALID_PIPE_SKID_EN, have no skid, a combinational ready_up = rdy[0], and capacity = STAGES.

Structure
REQ-029 SHALL take count width and capacity constants from shared package valid_pipe_pkg.
REQ-030 SHALL build each stage from sub-module valid_pipe_stage (one valid/data register pair with collapsing ready) instantiated STAGES times in a generate loop.

Verification (WIDTH=8, STAGES=3)
REQ-031 SHALL check streaming: send 0x01..0x10 with ready_down=1 -> first output 3 edges after acceptance, then 1 beat/cycle, in order.
REQ-032 SHALL check backpressure: ready_down=0 while sending 5 beats -> count reaches 3 (4 with skid), ready_up=0; release -> all beats out in order, data stable while stalled.
REQ-033 SHALL check bubble collapse: one beat 0xAA, then ready_down=0 -> the beat advances to stage 2 while upstream keeps being accepted until full.
REQ-034 SHALL check flush: fill 3 beats, assert flush together with valid_up and data 0x55 -> next cycle count=0, valid_down=0, and 0x55 never appears.
REQ-035 SHALL check reset mid-stream: assert rst=0 between edges with 2 beats held -> valid_down=0 and count=0 immediately; after release, no output until new input.
REQ-036 SHALL check SKID_EN builds: with ready_down toggling at random over 1000 beats -> scoreboard matches, and ready_up has no combinational path from ready_down.
